// File: rtl/megaram_pkg.sv
// Shared types and constants for the MegaRAM memory bridge.
package megaram_pkg;
    localparam int         MEGARAM_ADDR_W = 23;
    localparam logic [7:0] CDOUT_IDLE     = 8'hFF;

    typedef enum logic [1:0] {IDLE, SETTLE, REQ, HOLD} bridge_state_t;
endpackage

// File: rtl/megaram_mem_bridge_if.sv
// Request channel between the bridge (master) and the PSRAM controller (slave).
interface megaram_mem_bridge_if
    import megaram_pkg::*;
#(
    parameter int ADDR_W = MEGARAM_ADDR_W
);
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [7:0]        ext_wdata;
    logic              ext_ack;
    logic [7:0]        ext_rdata;

    modport master (
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_ack, ext_rdata
    );

    modport slave (
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_ack, ext_rdata
    );
endinterface

// File: rtl/megaram_mem_bridge_sync.sv
// Two-flop synchroniser for one asynchronous control strobe.
module bus_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ff_q <= {2{RST_VAL}};
        else         ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];
endmodule

// File: rtl/megaram_mem_bridge.sv
// Turns each mapper-selected Z80 slot cycle into exactly one PSRAM request,
// stretching the cycle with WAIT and returning read data on cdout.
module megaram_mem_bridge
    import megaram_pkg::*;
#(
    parameter int ADDR_W         = MEGARAM_ADDR_W,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 cart_ena_i,
    input  logic                 ram_ena_i,
    input  logic [ADDR_W-1:0]    mem_addr_i,
    input  logic [7:0]           cdin_i,
    input  logic                 rd_n_i,
    input  logic                 wr_n_i,
    megaram_mem_bridge_if.master mem,
    output logic [7:0]           cdout_o,
    output logic                 cdout_oe_o,
    output logic                 wait_n_o,
    output logic                 timeout_err_o
);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT_CYCLES - 1);

    logic cart_s, ram_s, rd_s, wr_s;

    bus_sync2 #(.RST_VAL(1'b0)) u_sync_cart (.clk_i, .rst_ni(reset_n_i), .d_i(cart_ena_i), .q_o(cart_s));
    bus_sync2 #(.RST_VAL(1'b0)) u_sync_ram  (.clk_i, .rst_ni(reset_n_i), .d_i(ram_ena_i),  .q_o(ram_s));
    bus_sync2 #(.RST_VAL(1'b1)) u_sync_rd   (.clk_i, .rst_ni(reset_n_i), .d_i(rd_n_i),     .q_o(rd_s));
    bus_sync2 #(.RST_VAL(1'b1)) u_sync_wr   (.clk_i, .rst_ni(reset_n_i), .d_i(wr_n_i),     .q_o(wr_s));

    logic rd_cyc, wr_cyc, cyc_any, bus_idle;

    // Both strobes low decodes to neither cycle type, so it is never serviced.
    assign rd_cyc   = cart_s & ~rd_s & wr_s;
    assign wr_cyc   = cart_s & ~wr_s & rd_s & ram_s;
    assign cyc_any  = rd_cyc | wr_cyc;
    assign bus_idle = rd_s & wr_s;

    bridge_state_t     state_q, state_d;
    logic [3:0]        settle_q, settle_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              typ_q, typ_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ended_q, ended_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        cdout_q, cdout_d;
    logic              oe_q, oe_d;
    logic              wait_n_q, wait_n_d;
    logic              terr_q, terr_d;
    logic              ended_now;
    logic              finish;

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        typ_d     = typ_q;
        addr_d    = addr_q;
        ended_d   = ended_q;
        req_d     = req_q;
        we_d      = we_q;
        eaddr_d   = eaddr_q;
        wdata_d   = wdata_q;
        cdout_d   = cdout_q;
        oe_d      = oe_q;
        wait_n_d  = wait_n_q;
        terr_d    = terr_q;
        ended_now = ended_q | bus_idle;
        finish    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cyc_any) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LOAD;
                    typ_d    = wr_cyc;
                    addr_d   = mem_addr_i;
                    wait_n_d = 1'b0;
                end
            end
            SETTLE: begin
                if (!cyc_any) begin
                    state_d  = IDLE;
                    wait_n_d = 1'b1;
                end else if (wr_cyc != typ_q || mem_addr_i != addr_q) begin
                    settle_d = SETTLE_LOAD;
                    typ_d    = wr_cyc;
                    addr_d   = mem_addr_i;
                end else if (settle_q == 4'd0) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = typ_q;
                    eaddr_d = addr_q;
                    wdata_d = cdin_i;
                    tmo_d   = 8'd0;
                    ended_d = 1'b0;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            REQ: begin
                // The controller cannot abort, so an early bus end only marks the data as unwanted.
                ended_d = ended_now;
                if (mem.ext_ack) begin
                    finish = 1'b1;
                    if (!ended_now && !we_q) cdout_d = mem.ext_rdata;
                end else if (tmo_q == TMO_LAST) begin
                    finish  = 1'b1;
                    cdout_d = CDOUT_IDLE;
                    terr_d  = 1'b1;
                end else begin
                    tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
                end
                if (finish) begin
                    req_d = 1'b0;
                    if (ended_now) begin
                        state_d  = IDLE;
                        wait_n_d = ~cyc_any;
                    end else begin
                        state_d  = HOLD;
                        wait_n_d = 1'b1;
                        oe_d     = ~we_q & ~rd_s;
                    end
                end
            end
            HOLD: begin
                wait_n_d = 1'b1;
                oe_d     = ~we_q & ~rd_s;
                if (bus_idle) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            settle_q <= '0;
            tmo_q    <= '0;
            typ_q    <= 1'b0;
            addr_q   <= '0;
            ended_q  <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            eaddr_q  <= '0;
            wdata_q  <= '0;
            cdout_q  <= CDOUT_IDLE;
            oe_q     <= 1'b0;
            wait_n_q <= 1'b1;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            typ_q    <= typ_d;
            addr_q   <= addr_d;
            ended_q  <= ended_d;
            req_q    <= req_d;
            we_q     <= we_d;
            eaddr_q  <= eaddr_d;
            wdata_q  <= wdata_d;
            cdout_q  <= cdout_d;
            oe_q     <= oe_d;
            wait_n_q <= wait_n_d;
            terr_q   <= terr_d;
        end
    end

    assign mem.ext_req   = req_q;
    assign mem.ext_we    = we_q;
    assign mem.ext_addr  = eaddr_q;
    assign mem.ext_wdata = wdata_q;
    assign cdout_o       = cdout_q;
    assign cdout_oe_o    = oe_q;
    assign wait_n_o      = wait_n_q;
    assign timeout_err_o = terr_q;
endmodule
